// File: rtl/spi_cmd_controller.sv
// Frames bytes from the SPI slave into register-bus commands: byte 0 is {rw, addr},
// later bytes are writes at auto-incrementing addresses, and a read result feeds the next frame's MISO.
module spi_cmd_controller #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic [7:0]        mosi_byte,
    input  logic              data_valid,
    output logic              spi_enable,
    output logic [7:0]        miso_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_valid,
    input  logic              reg_wr_ready,
    output logic              reg_rd_valid,
    input  logic              reg_rd_ready,
    input  logic [7:0]        reg_rdata,
    input  logic              err_clear,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {SYNC, IDLE, CMD, DATA, WR, RD, DRAIN} state_t;

    state_t        state;
    logic          cs_meta, cs_sync, cs_prev;
    logic          cs_fall;
    logic [TW-1:0] timer;
    logic          drain_pend;
    logic          overrun_evt, timeout_evt;

    // Sync regs reset low so SYNC only leaves once a real cs-high has been seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta <= 1'b0;
            cs_sync <= 1'b0;
            cs_prev <= 1'b0;
        end else begin
            cs_meta <= cs;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    assign cs_fall     = cs_prev & ~cs_sync;
    assign overrun_evt = data_valid & ((state == WR) | (state == RD));
    assign timeout_evt = (((state == WR) & ~reg_wr_ready) | ((state == RD) & ~reg_rd_ready))
                         & (timer == TIMER_LAST);
    assign spi_enable  = (state != SYNC);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SYNC;
            reg_addr     <= '0;
            reg_wdata    <= 8'h00;
            reg_wr_valid <= 1'b0;
            reg_rd_valid <= 1'b0;
            miso_byte    <= 8'h00;
            timer        <= '0;
            drain_pend   <= 1'b0;
        end else begin
            case (state)
                SYNC: if (cs_sync) state <= IDLE;
                IDLE: if (cs_fall) state <= CMD;
                CMD: begin
                    if (data_valid) begin
                        reg_addr <= mosi_byte[ADDR_W-1:0];
                        if (mosi_byte[7]) begin
                            state        <= RD;
                            reg_rd_valid <= 1'b1;
                            timer        <= '0;
                        end else begin
                            state <= DATA;
                        end
                    end else if (cs_sync) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (data_valid) begin
                        reg_wdata    <= mosi_byte;
                        reg_wr_valid <= 1'b1;
                        timer        <= '0;
                        drain_pend   <= 1'b0;
                        state        <= WR;
                    end else if (cs_sync) begin
                        state <= IDLE;
                    end
                end
                WR: begin
                    if (overrun_evt) drain_pend <= 1'b1;
                    if (reg_wr_ready) begin
                        reg_wr_valid <= 1'b0;
                        reg_addr     <= reg_addr + ADDR_W'(1);
                        if (cs_sync)                       state <= IDLE;
                        else if (drain_pend || data_valid) state <= DRAIN;
                        else                               state <= DATA;
                    end else if (timeout_evt) begin
                        reg_wr_valid <= 1'b0;
                        state        <= cs_sync ? IDLE : DRAIN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RD: begin
                    if (reg_rd_ready) begin
                        miso_byte    <= reg_rdata;
                        reg_rd_valid <= 1'b0;
                        state        <= cs_sync ? IDLE : DRAIN;
                    end else if (timeout_evt) begin
                        reg_rd_valid <= 1'b0;
                        state        <= cs_sync ? IDLE : DRAIN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: if (cs_sync) state <= IDLE;
                default: state <= SYNC;
            endcase
        end
    end

    // A set event in the same cycle as err_clear wins because it is assigned last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (err_clear) begin
                err_overrun <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (overrun_evt) err_overrun <= 1'b1;
            if (timeout_evt) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Scoreboard bench for spi_cmd_controller: expected bus transactions are queued as
// frames are driven and popped by a monitor as the DUT handshakes on the register bus.
module tb_spi_cmd_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b1;
    logic [7:0] mosi_byte = 8'h00;
    logic       data_valid = 1'b0;
    logic       spi_enable;
    logic [7:0] miso_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_valid;
    logic       reg_wr_ready = 1'b0;
    logic       reg_rd_valid;
    logic       reg_rd_ready = 1'b0;
    logic [7:0] reg_rdata = 8'h00;
    logic       err_clear = 1'b0;
    logic       err_overrun;
    logic       err_timeout;
    logic       busy;

    typedef struct packed {
        logic       is_rd;
        logic [6:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    spi_cmd_controller #(.ADDR_W(7), .TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .mosi_byte(mosi_byte),
        .data_valid(data_valid), .spi_enable(spi_enable), .miso_byte(miso_byte),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_valid(reg_wr_valid),
        .reg_wr_ready(reg_wr_ready), .reg_rd_valid(reg_rd_valid),
        .reg_rd_ready(reg_rd_ready), .reg_rdata(reg_rdata), .err_clear(err_clear),
        .err_overrun(err_overrun), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so negedge values equal those seen at the next posedge.
    always @(negedge clk) begin
        txn_t got, exp;
        if (reset_n && ((reg_wr_valid && reg_wr_ready) || (reg_rd_valid && reg_rd_ready))) begin
            got = reg_wr_valid ? {1'b0, reg_addr, reg_wdata} : {1'b1, reg_addr, reg_rdata};
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL bus_txn unexpected: got rd=%0b addr=%h data=%h, required none",
                         got.is_rd, got.addr, got.data);
            end else begin
                exp = expq.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL bus_txn: got rd=%0b addr=%h data=%h, required rd=%0b addr=%h data=%h",
                             got.is_rd, got.addr, got.data, exp.is_rd, exp.addr, exp.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        mosi_byte  = b;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        tick(5);
    endtask

    task automatic expect_wr(input logic [6:0] a, input logic [7:0] d);
        expq.push_back({1'b0, a, d});
    endtask

    task automatic check_queue_empty(input string name);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s pending: %0d transactions outstanding, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cs = 1'b1;
        tick(3);
        vectors++;
        if ({spi_enable, reg_wr_valid, reg_rd_valid, err_overrun, err_timeout} !== 5'b0 ||
            miso_byte !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: en=%b wv=%b rv=%b eo=%b et=%b miso=%h, required all 0",
                     spi_enable, reg_wr_valid, reg_rd_valid, err_overrun, err_timeout, miso_byte);
        end
        reset_n = 1'b1;
        tick(5);
        vectors++;
        if (spi_enable !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: en=%b busy=%b, required en=1 busy=0", spi_enable, busy);
        end
    endtask

    task automatic test_write_burst();
        reg_wr_ready = 1'b1;
        expect_wr(7'h05, 8'hAA);
        expect_wr(7'h06, 8'hBB);
        frame_start();
        send_byte(8'h05); tick(3);
        send_byte(8'hAA); tick(4);
        send_byte(8'hBB); tick(4);
        vectors++;
        if (reg_addr !== 7'h07) begin
            miscompares++;
            $display("[TB] FAIL burst_addr: got %h, required 07", reg_addr);
        end
        frame_end();
        vectors++;
        if (busy !== 1'b0 || err_overrun !== 1'b0 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_end: busy=%b eo=%b et=%b, required 0 0 0", busy, err_overrun, err_timeout);
        end
        check_queue_empty("burst");
    endtask

    task automatic test_addr_wrap();
        expect_wr(7'h7F, 8'h11);
        expect_wr(7'h00, 8'h22);
        frame_start();
        send_byte(8'h7F); tick(3);
        send_byte(8'h11); tick(4);
        send_byte(8'h22); tick(4);
        frame_end();
        check_queue_empty("wrap");
    endtask

    task automatic test_read();
        reg_rd_ready = 1'b1;
        reg_rdata    = 8'h5C;
        expq.push_back({1'b1, 7'h03, 8'h5C});
        frame_start();
        send_byte(8'h83); tick(4);
        send_byte(8'hEE); tick(4);
        vectors++;
        if (miso_byte !== 8'h5C || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL read_capture: miso=%h busy=%b, required 5c 1", miso_byte, busy);
        end
        frame_end();
        reg_rdata = 8'h00;
        check_queue_empty("read");
        expect_wr(7'h20, 8'h33);
        frame_start();
        vectors++;
        if (miso_byte !== 8'h5C) begin
            miscompares++;
            $display("[TB] FAIL read_next_frame_miso: got %h, required 5c", miso_byte);
        end
        send_byte(8'h20); tick(3);
        send_byte(8'h33); tick(4);
        frame_end();
        reg_rd_ready = 1'b0;
        vectors++;
        if (miso_byte !== 8'h5C) begin
            miscompares++;
            $display("[TB] FAIL read_miso_hold: got %h, required 5c", miso_byte);
        end
        check_queue_empty("read_followup");
    endtask

    task automatic test_overrun();
        reg_wr_ready = 1'b0;
        expect_wr(7'h10, 8'h01);
        frame_start();
        send_byte(8'h10); tick(3);
        send_byte(8'h01); tick(4);
        send_byte(8'h02); tick(3);
        vectors++;
        if (err_overrun !== 1'b1 || reg_wr_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overrun_flag: eo=%b wv=%b, required 1 1", err_overrun, reg_wr_valid);
        end
        reg_wr_ready = 1'b1;
        tick(3);
        send_byte(8'h03); tick(4);
        vectors++;
        if (busy !== 1'b1 || reg_wr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overrun_drain: busy=%b wv=%b, required 1 0", busy, reg_wr_valid);
        end
        frame_end();
        vectors++;
        if (err_overrun !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overrun_sticky: eo=%b busy=%b, required 1 0", err_overrun, busy);
        end
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        vectors++;
        if (err_overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overrun_clear: got %b, required 0", err_overrun);
        end
        check_queue_empty("overrun");
    endtask

    task automatic test_timeout();
        int high_cycles = 0;
        reg_wr_ready = 1'b0;
        frame_start();
        send_byte(8'h40); tick(3);
        send_byte(8'h99);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (reg_wr_valid) high_cycles++;
            else break;
        end
        tick(2);
        vectors++;
        if (high_cycles != 255) begin
            miscompares++;
            $display("[TB] FAIL timeout_len: valid high %0d cycles, required 255", high_cycles);
        end
        vectors++;
        if (err_timeout !== 1'b1 || err_overrun !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_flags: et=%b eo=%b busy=%b, required 1 0 1",
                     err_timeout, err_overrun, busy);
        end
        frame_end();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        vectors++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_clear: et=%b busy=%b, required 0 0", err_timeout, busy);
        end
        check_queue_empty("timeout");
    endtask

    task automatic test_reset_mid_frame();
        reg_wr_ready = 1'b0;
        frame_start();
        send_byte(8'h30); tick(3);
        send_byte(8'h55); tick(3);
        vectors++;
        if (reg_wr_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_pending: wv=%b, required 1", reg_wr_valid);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (reg_wr_valid !== 1'b0 || miso_byte !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midreset_drop: wv=%b miso=%h, required 0 00", reg_wr_valid, miso_byte);
        end
        tick(2);
        reg_wr_ready = 1'b1;
        reset_n = 1'b1;
        tick(6);
        send_byte(8'h05); tick(3);
        send_byte(8'h66); tick(3);
        vectors++;
        if (spi_enable !== 1'b0 || reg_wr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_sync: en=%b wv=%b, required 0 0", spi_enable, reg_wr_valid);
        end
        frame_end();
        vectors++;
        if (spi_enable !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle: en=%b busy=%b, required 1 0", spi_enable, busy);
        end
        expect_wr(7'h21, 8'h44);
        frame_start();
        send_byte(8'h21); tick(3);
        send_byte(8'h44); tick(4);
        frame_end();
        check_queue_empty("midreset_frame");
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_addr_wrap();
        test_read();
        test_overrun();
        test_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
